// File: rtl/aes_pkg.sv
// Shared types for the AES-128 control and datapath blocks.
package aes_pkg;

    typedef logic [7:0] aes_byte;

    // AESDEC is a reserved encoding; aes_ctrl rejects it with an error_o pulse.
    typedef enum logic [1:0] {
        AESKEYEXP  = 2'd0,
        AESENC     = 2'd1,
        AESENCFULL = 2'd2,
        AESDEC     = 2'd3
    } opcode;

endpackage : aes_pkg

// File: rtl/aes_ctrl_if.sv
// Command handshake and datapath strobe bundle for aes_ctrl.
// The abort_i signal exists only when AES_CTRL_ABORT_EN is defined.
interface aes_ctrl_if;
    import aes_pkg::*;

    opcode   opcode_i;
    logic    start_i;
`ifdef AES_CTRL_ABORT_EN
    logic    abort_i;
`endif
    logic    busy_o;
    logic    key_ready_o;
    logic    cipher_ready_o;
    logic    error_o;
    logic    key_load_o;
    logic    key_gen_en_o;
    aes_byte r_con_o;
    logic    pt_load_o;
    logic    enc_en_o;
    logic    last_round_o;
    logic    [3:0] round_o;

`ifdef AES_CTRL_ABORT_EN
    modport master (
        output opcode_i, start_i, abort_i,
        input  busy_o, key_ready_o, cipher_ready_o, error_o,
               key_load_o, key_gen_en_o, r_con_o, pt_load_o,
               enc_en_o, last_round_o, round_o
    );

    modport slave (
        input  opcode_i, start_i, abort_i,
        output busy_o, key_ready_o, cipher_ready_o, error_o,
               key_load_o, key_gen_en_o, r_con_o, pt_load_o,
               enc_en_o, last_round_o, round_o
    );
`else
    modport master (
        output opcode_i, start_i,
        input  busy_o, key_ready_o, cipher_ready_o, error_o,
               key_load_o, key_gen_en_o, r_con_o, pt_load_o,
               enc_en_o, last_round_o, round_o
    );

    modport slave (
        input  opcode_i, start_i,
        output busy_o, key_ready_o, cipher_ready_o, error_o,
               key_load_o, key_gen_en_o, r_con_o, pt_load_o,
               enc_en_o, last_round_o, round_o
    );
`endif

endinterface : aes_ctrl_if

// File: rtl/aes_ctrl.sv
// aes_ctrl: command sequencer for the iterative AES-128 key expansion and
// cipher datapath. Accepts opcode/start in IDLE, drives load/enable/round/
// r_con strobes into key_gen and aes_enc, reports busy/ready/error.
// Optional feature macro: AES_CTRL_ABORT_EN (adds abort_i to the bus).
module aes_ctrl #(
    parameter int               NR        = 10,
    parameter aes_pkg::aes_byte RCON_INIT = 8'h01
) (
    input  logic       clk,
    input  logic       nrst,
    aes_ctrl_if.slave  bus
);
    import aes_pkg::*;

    localparam logic [3:0] NR_R    = 4'(NR);
    localparam logic [3:0] NR_M1_R = 4'(NR - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY_LOAD  = 3'd1,
        KEY_EXP   = 3'd2,
        ENC_INIT  = 3'd3,
        ENC_ROUND = 3'd4,
        ENC_FINAL = 3'd5,
        DONE      = 3'd6
    } state_t;

    // GF(2^8) doubling used to step the round constant.
    function automatic aes_byte xtime(input aes_byte b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    state_t     state_r;
    opcode      op_r;
    logic       busy_r;
    logic       key_ready_r;
    logic       cipher_ready_r;
    logic       error_r;
    logic       key_load_r;
    logic       key_gen_en_r;
    aes_byte    r_con_r;
    logic       pt_load_r;
    logic       enc_en_r;
    logic       last_round_r;
    logic [3:0] round_r;

    // Command FSM: state, latched opcode and every registered output.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r        <= IDLE;
            op_r           <= AESKEYEXP;
            busy_r         <= 1'b0;
            key_ready_r    <= 1'b0;
            cipher_ready_r <= 1'b0;
            error_r        <= 1'b0;
            key_load_r     <= 1'b0;
            key_gen_en_r   <= 1'b0;
            r_con_r        <= 8'h00;
            pt_load_r      <= 1'b0;
            enc_en_r       <= 1'b0;
            last_round_r   <= 1'b0;
            round_r        <= 4'd0;
        end else begin
            // Strobes and pulses are single-cycle unless re-asserted below.
            cipher_ready_r <= 1'b0;
            error_r        <= 1'b0;
            key_load_r     <= 1'b0;
            key_gen_en_r   <= 1'b0;
            r_con_r        <= 8'h00;
            pt_load_r      <= 1'b0;
            enc_en_r       <= 1'b0;
            last_round_r   <= 1'b0;
            round_r        <= 4'd0;
`ifdef AES_CTRL_ABORT_EN
            // busy_r is high exactly in the abortable states; key_ready_r is
            // left alone so an aborted encryption keeps the expanded key.
            if (bus.abort_i && busy_r) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
                error_r <= 1'b1;
            end else
`endif
            begin
                case (state_r)
                    IDLE: begin
                        if (bus.start_i) begin
                            case (bus.opcode_i)
                                AESKEYEXP, AESENCFULL: begin
                                    op_r        <= bus.opcode_i;
                                    state_r     <= KEY_LOAD;
                                    busy_r      <= 1'b1;
                                    key_ready_r <= 1'b0;
                                    key_load_r  <= 1'b1;
                                end
                                AESENC: begin
                                    if (key_ready_r) begin
                                        op_r      <= bus.opcode_i;
                                        state_r   <= ENC_INIT;
                                        busy_r    <= 1'b1;
                                        pt_load_r <= 1'b1;
                                    end else begin
                                        error_r <= 1'b1;
                                    end
                                end
                                default: begin
                                    error_r <= 1'b1;
                                end
                            endcase
                        end else begin
                            busy_r <= 1'b0;
                        end
                    end
                    KEY_LOAD: begin
                        state_r      <= KEY_EXP;
                        key_gen_en_r <= 1'b1;
                        round_r      <= 4'd1;
                        r_con_r      <= RCON_INIT;
                    end
                    KEY_EXP: begin
                        if (round_r == NR_R) begin
                            key_ready_r <= 1'b1;
                            if (op_r == AESENCFULL) begin
                                state_r   <= ENC_INIT;
                                pt_load_r <= 1'b1;
                            end else begin
                                state_r <= DONE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            key_gen_en_r <= 1'b1;
                            round_r      <= round_r + 4'd1;
                            r_con_r      <= xtime(r_con_r);
                        end
                    end
                    ENC_INIT: begin
                        state_r  <= ENC_ROUND;
                        enc_en_r <= 1'b1;
                        round_r  <= 4'd1;
                    end
                    ENC_ROUND: begin
                        enc_en_r <= 1'b1;
                        if (round_r == NR_M1_R) begin
                            state_r      <= ENC_FINAL;
                            last_round_r <= 1'b1;
                            round_r      <= NR_R;
                        end else begin
                            round_r <= round_r + 4'd1;
                        end
                    end
                    ENC_FINAL: begin
                        state_r        <= DONE;
                        busy_r         <= 1'b0;
                        cipher_ready_r <= 1'b1;
                    end
                    DONE: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy_o         = busy_r;
    assign bus.key_ready_o    = key_ready_r;
    assign bus.cipher_ready_o = cipher_ready_r;
    assign bus.error_o        = error_r;
    assign bus.key_load_o     = key_load_r;
    assign bus.key_gen_en_o   = key_gen_en_r;
    assign bus.r_con_o        = r_con_r;
    assign bus.pt_load_o      = pt_load_r;
    assign bus.enc_en_o       = enc_en_r;
    assign bus.last_round_o   = last_round_r;
    assign bus.round_o        = round_r;

endmodule : aes_ctrl

// File: tb/tb_aes_ctrl.sv
// Directed bench for aes_ctrl: reset values, command latencies, r_con
// sequence, error cases, start filtering, async reset and optional abort.
module tb_aes_ctrl;
    import aes_pkg::*;

    logic clk;
    logic nrst;
    int   checks;
    int   failures;
    int   pulses;
    int   pulse_cyc;
    int   errs;

    aes_ctrl_if bus ();

    aes_ctrl #(.NR(10), .RCON_INIT(8'h01)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start at the current sample point; returns in cycle 1.
    task automatic issue(input opcode op);
        bus.opcode_i = op;
        bus.start_i  = 1'b1;
        @(negedge clk);
        bus.start_i  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   {31'd0, bus.busy_o},        32'd0);
        chk({tag, "_kready"}, {31'd0, bus.key_ready_o},   32'd0);
        chk({tag, "_cready"}, {31'd0, bus.cipher_ready_o},32'd0);
        chk({tag, "_err"},    {31'd0, bus.error_o},       32'd0);
        chk({tag, "_kload"},  {31'd0, bus.key_load_o},    32'd0);
        chk({tag, "_kgen"},   {31'd0, bus.key_gen_en_o},  32'd0);
        chk({tag, "_rcon"},   {24'd0, bus.r_con_o},       32'd0);
        chk({tag, "_ptload"}, {31'd0, bus.pt_load_o},     32'd0);
        chk({tag, "_encen"},  {31'd0, bus.enc_en_o},      32'd0);
        chk({tag, "_last"},   {31'd0, bus.last_round_o},  32'd0);
        chk({tag, "_round"},  {28'd0, bus.round_o},       32'd0);
    endtask

    logic [7:0] rcon_tab [10];
    opcode      noise_ops [3];

    initial begin
        checks    = 0;
        failures  = 0;
        rcon_tab  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        noise_ops = '{AESENC, AESDEC, AESKEYEXP};
        nrst         = 1'b0;
        bus.start_i  = 1'b0;
        bus.opcode_i = AESKEYEXP;
`ifdef AES_CTRL_ABORT_EN
        bus.abort_i  = 1'b0;
`endif
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // AESENC with no expanded key is rejected.
        issue(AESENC);
        chk("enc_nokey_err", {31'd0, bus.error_o}, 32'd1);
        chk("enc_nokey_busy", {31'd0, bus.busy_o}, 32'd0);
        @(negedge clk);
        chk("enc_nokey_err_c2", {31'd0, bus.error_o}, 32'd0);
        chk("enc_nokey_busy_c2", {31'd0, bus.busy_o}, 32'd0);

        // Unimplemented opcode is rejected.
        issue(AESDEC);
        chk("illegal_err", {31'd0, bus.error_o}, 32'd1);
        chk("illegal_busy", {31'd0, bus.busy_o}, 32'd0);
        @(negedge clk);

        // Key expansion: load in cycle 1, rounds 1..10 in cycles 2..11, done in 12.
        issue(AESKEYEXP);
        chk("kx_c1_load", {31'd0, bus.key_load_o}, 32'd1);
        chk("kx_c1_busy", {31'd0, bus.busy_o}, 32'd1);
        chk("kx_c1_rcon", {24'd0, bus.r_con_o}, 32'd0);
        for (int c = 2; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("kx_c%0d_rcon", c), {24'd0, bus.r_con_o}, {24'd0, rcon_tab[c-2]});
            chk($sformatf("kx_c%0d_round", c), {28'd0, bus.round_o}, 32'(c - 1));
            chk($sformatf("kx_c%0d_kgen", c), {31'd0, bus.key_gen_en_o}, 32'd1);
            chk($sformatf("kx_c%0d_kready", c), {31'd0, bus.key_ready_o}, 32'd0);
        end
        @(negedge clk);
        chk("kx_c12_kready", {31'd0, bus.key_ready_o}, 32'd1);
        chk("kx_c12_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("kx_c12_kgen", {31'd0, bus.key_gen_en_o}, 32'd0);
        chk("kx_c12_cready", {31'd0, bus.cipher_ready_o}, 32'd0);
        @(negedge clk);
        chk("kx_c13_kready", {31'd0, bus.key_ready_o}, 32'd1);

        // Two AESENC commands; the second starts in the IDLE cycle after DONE.
        for (int k = 0; k < 2; k++) begin
            issue(AESENC);
            chk($sformatf("enc%0d_ptload", k), {31'd0, bus.pt_load_o}, 32'd1);
            pulses    = 0;
            pulse_cyc = 0;
            for (int c = 1; c <= 12; c++) begin
                if (c > 1) @(negedge clk);
                if (c == 11) begin
                    chk($sformatf("enc%0d_last", k), {31'd0, bus.last_round_o}, 32'd1);
                    chk($sformatf("enc%0d_round10", k), {28'd0, bus.round_o}, 32'd10);
                end
                if (bus.cipher_ready_o === 1'b1) begin
                    pulses++;
                    pulse_cyc = c;
                end
            end
            chk($sformatf("enc%0d_pulses", k), 32'(pulses), 32'd1);
            chk($sformatf("enc%0d_pulse_cyc", k), 32'(pulse_cyc), 32'd12);
            chk($sformatf("enc%0d_kready", k), {31'd0, bus.key_ready_o}, 32'd1);
            @(negedge clk);
            chk($sformatf("enc%0d_idle_busy", k), {31'd0, bus.busy_o}, 32'd0);
        end

        // AESENCFULL with start held high and opcode churning meanwhile.
        bus.opcode_i = AESENCFULL;
        bus.start_i  = 1'b1;
        @(negedge clk);
        pulses    = 0;
        pulse_cyc = 0;
        errs      = 0;
        for (int c = 1; c <= 23; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) begin
                chk("full_c1_kready", {31'd0, bus.key_ready_o}, 32'd0);
                chk("full_c1_kload", {31'd0, bus.key_load_o}, 32'd1);
            end
            if (c == 11) chk("full_c11_rcon", {24'd0, bus.r_con_o}, 32'h36);
            if (c == 12) begin
                chk("full_c12_kready", {31'd0, bus.key_ready_o}, 32'd1);
                chk("full_c12_ptload", {31'd0, bus.pt_load_o}, 32'd1);
                chk("full_c12_busy", {31'd0, bus.busy_o}, 32'd1);
            end
            if (c == 22) chk("full_c22_last", {31'd0, bus.last_round_o}, 32'd1);
            if (bus.cipher_ready_o === 1'b1) begin
                pulses++;
                pulse_cyc = c;
            end
            if (bus.error_o === 1'b1) errs++;
            if (c < 23) bus.opcode_i = noise_ops[c % 3];
            else bus.start_i = 1'b0;
        end
        chk("full_pulses", 32'(pulses), 32'd1);
        chk("full_pulse_cyc", 32'(pulse_cyc), 32'd23);
        chk("full_errors", 32'(errs), 32'd0);
        @(negedge clk);
        chk("full_c24_busy", {31'd0, bus.busy_o}, 32'd0);
        @(negedge clk);
        chk("full_c25_busy", {31'd0, bus.busy_o}, 32'd0);

        // Asynchronous reset in cycle 6 of AESENCFULL.
        issue(AESENCFULL);
        for (int c = 2; c <= 6; c++) @(negedge clk);
        chk("rst_pre_kgen", {31'd0, bus.key_gen_en_o}, 32'd1);
        #1 nrst = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        nrst   = 1'b1;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.cipher_ready_o === 1'b1) pulses++;
        end
        chk("midrst_pulses", 32'(pulses), 32'd0);
        chk("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("midrst_kready", {31'd0, bus.key_ready_o}, 32'd0);
        issue(AESENC);
        chk("midrst_enc_err", {31'd0, bus.error_o}, 32'd1);
        @(negedge clk);

`ifdef AES_CTRL_ABORT_EN
        // Abort in cycle 15 of AESENCFULL keeps the expanded key.
        issue(AESENCFULL);
        for (int c = 2; c <= 15; c++) @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("abort_err", {31'd0, bus.error_o}, 32'd1);
        chk("abort_kready", {31'd0, bus.key_ready_o}, 32'd1);
        chk("abort_encen", {31'd0, bus.enc_en_o}, 32'd0);
        pulses = 0;
        errs   = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.cipher_ready_o === 1'b1) pulses++;
            if (bus.error_o === 1'b1) errs++;
        end
        chk("abort_pulses", 32'(pulses), 32'd0);
        chk("abort_err_once", 32'(errs), 32'd0);

        // Abort during key expansion leaves no valid key.
        issue(AESKEYEXP);
        for (int c = 2; c <= 4; c++) @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort_kx_kready", {31'd0, bus.key_ready_o}, 32'd0);
        chk("abort_kx_kgen", {31'd0, bus.key_gen_en_o}, 32'd0);
        chk("abort_kx_err", {31'd0, bus.error_o}, 32'd1);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_aes_ctrl
